// File: rtl/dds_gain_decimator_if.sv
// Output stream of the DDS gain/decimator stage: valid/ready handshake carrying one sample.
interface dds_gain_decimator_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] bits;

  modport master (output valid, output bits, input ready);
  modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/dds_gain_decimator.sv
// Q1.15 gain with saturation, runtime decimation and a small output FIFO
// behind a valid/ready stream, fed by the free-running CWCore sample stream.
module dds_gain_decimator #(
  parameter  int DATA_W     = 32,
  parameter  int GAIN_W     = 16,
  parameter  int DECIM_W    = 8,
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_en,
  input  logic [DATA_W-1:0]     io_in_value,
  input  logic [GAIN_W-1:0]     io_gain,
  input  logic [DECIM_W-1:0]    io_decim,
  dds_gain_decimator_if.master  io_out,
  output logic [LVL_W-1:0]      io_level,
  output logic [15:0]           io_overflow_cnt
);

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------- gain stage ----------------
  logic signed [PROD_W-1:0] in_ext, gain_ext, prod, prod_sh;
  logic [PROD_W-DATA_W:0]   prod_hi;
  logic [DATA_W-1:0]        gained;
  logic [DATA_W-1:0]        s1;
  logic                     s1_valid;

  always_comb begin
    in_ext   = {{GAIN_W{io_in_value[DATA_W-1]}}, io_in_value};
    gain_ext = {{DATA_W{io_gain[GAIN_W-1]}}, io_gain};
    prod     = in_ext * gain_ext;
    prod_sh  = prod >>> (GAIN_W - 1);
    // Result fits only if every bit above the output sign bit matches it.
    prod_hi  = prod_sh[PROD_W-1:DATA_W-1];
    if ((prod_hi == '0) || (prod_hi == '1)) gained = prod_sh[DATA_W-1:0];
    else if (prod_sh[PROD_W-1])             gained = SAT_MIN;
    else                                    gained = SAT_MAX;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1       <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1       <= gained;
      s1_valid <= io_en;
    end
  end

  // ---------------- decimator ----------------
  logic [DECIM_W-1:0] cnt, d_q, d_eff;
  logic               emit;
  logic               dec_valid;
  logic [DATA_W-1:0]  dec_data;

  // A new factor is taken only at window start; it applies to that same sample.
  always_comb begin
    d_eff = (cnt == '0) ? io_decim : d_q;
    emit  = s1_valid && (cnt == d_eff);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      d_q       <= '0;
      dec_valid <= 1'b0;
      dec_data  <= '0;
    end else begin
      dec_valid <= emit;
      if (emit) dec_data <= s1;
      if (s1_valid) begin
        if (cnt == '0) d_q <= io_decim;
        cnt <= emit ? '0 : cnt + 1'b1;
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nx;
  logic [LVL_W-1:0]  level, level_nx;
  logic [DATA_W-1:0] bits_q, head_nx;
  logic              pop, full, push_ok, drop;

  always_comb begin
    pop     = (level != '0) && io_out.ready;
    full    = (level == FULL_LVL);
    push_ok = dec_valid && (!full || pop);
    drop    = dec_valid && full && !pop;
    rd_nx   = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nx = level;
    case ({push_ok, pop})
      2'b10:   level_nx = level + 1'b1;
      2'b01:   level_nx = level - 1'b1;
      default: level_nx = level;
    endcase
    // Registered head: bypass the write when the new entry becomes the head.
    if (level_nx == '0)                   head_nx = '0;
    else if (push_ok && wr_ptr == rd_nx)  head_nx = dec_data;
    else                                  head_nx = mem[rd_nx];
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= dec_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      bits_q          <= '0;
      io_overflow_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nx;
      level  <= level_nx;
      bits_q <= head_nx;
      if (drop && io_overflow_cnt != '1) io_overflow_cnt <= io_overflow_cnt + 1'b1;
    end
  end

  assign io_out.valid = (level != '0);
  assign io_out.bits  = bits_q;
  assign io_level     = level;

endmodule

// File: tb/tb_dds_gain_decimator.sv
// Directed checks of gain, saturation, decimation, FIFO overflow/drain and async reset.
module tb_dds_gain_decimator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en    = 1'b0;
  logic [31:0] in_value = '0;
  logic [15:0] gain  = '0;
  logic [7:0]  decim = '0;
  logic [3:0]  level;
  logic [15:0] ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] got [$];

  dds_gain_decimator_if #(.DATA_W(32)) out_if ();

  dds_gain_decimator #(
    .DATA_W(32), .GAIN_W(16), .DECIM_W(8), .FIFO_DEPTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_en(en),
    .io_in_value(in_value),
    .io_gain(gain),
    .io_decim(decim),
    .io_out(out_if.master),
    .io_level(level),
    .io_overflow_cnt(ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (out_if.valid && out_if.ready) got.push_back(out_if.bits);
  endtask

  task automatic drive(input logic [31:0] v);
    en = 1'b1;
    in_value = v;
    tick();
  endtask

  task automatic idle(input int unsigned n);
    en = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, out_if.bits, exp);
    out_if.ready = 1'b1;
    @(negedge clock);
    out_if.ready = 1'b0;
  endtask

  initial begin
    out_if.ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_if.valid), 32'd0);
    check("rst_bits",  out_if.bits, 32'd0);
    check("rst_ovf",   32'(ovf), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Latency: single sample, gain 0.5
    gain = 16'h4000; decim = 8'd0;
    drive(32'd1000);
    en = 1'b0;
    check("lat_valid_n", 32'(out_if.valid), 32'd0);
    @(negedge clock);
    check("lat_valid_n1", 32'(out_if.valid), 32'd0);
    @(negedge clock);
    check("lat_valid_n2", 32'(out_if.valid), 32'd1);
    pop_check("gain_half", 32'd500);

    // Gain vectors incl. floor and saturation
    drive(32'hFFFF_FFFD);
    gain = 16'h7FFF; drive(32'h7FFF_FFFF);
    gain = 16'h8000; drive(32'h8000_0000);
    idle(4);
    check("gain_level", 32'(level), 32'd3);
    pop_check("gain_floor", 32'hFFFF_FFFE);
    pop_check("gain_max",   32'h7FFE_FFFF);
    pop_check("gain_sat",   32'h7FFF_FFFF);
    check("sat_ovf",    32'(ovf), 32'd0);
    check("drain_valid", 32'(out_if.valid), 32'd0);
    check("drain_bits",  out_if.bits, 32'd0);

    // Decimation by 4 on a ramp
    gain = 16'h7FFF; decim = 8'd3; out_if.ready = 1'b1;
    got.delete();
    for (int unsigned k = 0; k < 12; k++) drive(32'(k * 32768));
    idle(5);
    check("dec_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("dec_0", got[0], 32'd98301);
      check("dec_1", got[1], 32'd229369);
      check("dec_2", got[2], 32'd360437);
    end

    // Factor change mid-window applies at the next window
    got.delete();
    for (int unsigned k = 0; k < 8; k++) begin
      if (k == 2) decim = 8'd1;
      drive(32'(k * 32768));
    end
    idle(5);
    check("mid_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("mid_0", got[0], 32'd98301);
      check("mid_1", got[1], 32'd163835);
      check("mid_2", got[2], 32'd229369);
    end
    out_if.ready = 1'b0; decim = 8'd0;

    // Overflow: 12 samples into an 8-deep FIFO
    gain = 16'h4000;
    for (int unsigned k = 1; k <= 12; k++) drive(32'(k * 200));
    idle(4);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_cnt",   32'(ovf), 32'd4);
    check("ovf_valid", 32'(out_if.valid), 32'd1);
    for (int unsigned k = 1; k <= 8; k++) pop_check("ovf_drain", 32'(k * 100));
    check("ovf_empty", 32'(level), 32'd0);

    // Full FIFO with push and pop on the same edge
    for (int unsigned k = 1; k <= 8; k++) drive(32'(k * 200));
    idle(4);
    check("full_level", 32'(level), 32'd8);
    drive(32'd1800);
    en = 1'b0;
    @(negedge clock);
    out_if.ready = 1'b1;
    @(negedge clock);
    out_if.ready = 1'b0;
    idle(2);
    check("pp_level", 32'(level), 32'd8);
    check("pp_ovf",   32'(ovf), 32'd4);
    for (int unsigned k = 2; k <= 8; k++) pop_check("pp_drain", 32'(k * 100));
    pop_check("pp_last", 32'd900);
    check("pp_empty", 32'(level), 32'd0);

    // Async reset with FIFO at level 5
    for (int unsigned k = 1; k <= 5; k++) drive(32'(k * 2000));
    idle(4);
    check("rst5_level", 32'(level), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_if.valid), 32'd0);
    check("arst_bits",  out_if.bits, 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_ovf",   32'(ovf), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(32'd1554);
    idle(4);
    check("post_level", 32'(level), 32'd1);
    pop_check("post_bits", 32'd777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
